// File: rtl/asrm_regbank.sv
// Register bank for a small accumulator/stack machine: WR, PC, SR, SP and 12 GP
// registers, plus a RUN/ENTER/HALT sequencer handling interrupt entry and halt.
module asrm_regbank #(
  parameter int                  WORDSIZE    = 16,
  parameter logic [WORDSIZE-1:0] PC_RESET    = '0,
  parameter logic [WORDSIZE-1:0] SP_RESET    = '0,
  parameter logic [WORDSIZE-1:0] SR_RESET    = '0,
  parameter logic [WORDSIZE-1:0] GP_RESET    = '0,
  parameter int                  INT_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                wr_valid,
  input  logic [3:0]          wr_idx,
  input  logic [WORDSIZE-1:0] wr_data,
  input  logic [1:0]          sp_op,
  input  logic [7:0]          sp_step,
  input  logic                halt_req,
  input  logic                reti,
  input  logic                int_req,
  input  logic [WORDSIZE-1:0] int_vector,
  output logic                int_ack,
  input  logic [3:0]          rd_idx,
  output logic [WORDSIZE-1:0] rd_data,
  output logic [WORDSIZE-1:0] wr_reg,
  output logic [WORDSIZE-1:0] pc,
  output logic [WORDSIZE-1:0] sr,
  output logic [WORDSIZE-1:0] sp,
  output logic                halted,
  output logic                in_int
);

  typedef enum logic [1:0] {RUN, ENTER, HALT} state_t;

  localparam logic [1:0] LAT_LAST = 2'(INT_LATENCY - 1);

  state_t              state_q, state_d;
  logic [WORDSIZE-1:0] regs [16];
  logic [WORDSIZE-1:0] shadow_pc;
  logic [1:0]          lat_cnt;
  logic                accept, normal, do_reti, enter_done;
  logic [WORDSIZE-1:0] sp_delta;

  assign sp_delta = {{(WORDSIZE-8){1'b0}}, sp_step};

  always_ff @(posedge clk) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Sequencer: stall gates every decision, so no qualified action fires while frozen.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    normal     = 1'b0;
    do_reti    = 1'b0;
    enter_done = 1'b0;
    if (!stall) begin
      case (state_q)
        RUN: begin
          if (halt_req) begin
            state_d = HALT;
          end else if (int_req && !in_int) begin
            accept  = 1'b1;
            state_d = ENTER;
          end else begin
            normal  = 1'b1;
            do_reti = reti && in_int;
          end
        end
        ENTER: begin
          if (lat_cnt == LAT_LAST) begin
            enter_done = 1'b1;
            state_d    = RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= GP_RESET;
      regs[1]   <= PC_RESET;
      regs[2]   <= SR_RESET;
      regs[3]   <= SP_RESET;
      shadow_pc <= '0;
      lat_cnt   <= '0;
      in_int    <= 1'b0;
      int_ack   <= 1'b0;
    end else begin
      int_ack <= accept;
      if (accept) begin
        shadow_pc <= regs[1];
        in_int    <= 1'b1;
        lat_cnt   <= '0;
      end
      if (state_q == ENTER && !stall) lat_cnt <= lat_cnt + 2'd1;
      if (enter_done) regs[1] <= int_vector;
      if (normal) begin
        if (sp_op == 2'b01)      regs[3] <= regs[3] + sp_delta;
        else if (sp_op == 2'b10) regs[3] <= regs[3] - sp_delta;
        // Explicit register write lands after the SP arithmetic so wr_idx=3 wins.
        if (wr_valid) regs[wr_idx] <= wr_data;
        if (do_reti) begin
          regs[1] <= shadow_pc;
          in_int  <= 1'b0;
        end else if (!(wr_valid && wr_idx == 4'd1)) begin
          regs[1] <= regs[1] + WORDSIZE'(1);
        end
      end
    end
  end

  assign rd_data = regs[rd_idx];
  assign wr_reg  = regs[0];
  assign pc      = regs[1];
  assign sr      = regs[2];
  assign sp      = regs[3];
  assign halted  = (state_q == HALT);

endmodule

// File: tb/tb_asrm_regbank.sv
// Directed bench for asrm_regbank: expectations queued per step, checked after each edge.
module tb_asrm_regbank;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset, stall, wr_valid, halt_req, reti, int_req;
  logic [3:0]   wr_idx, rd_idx;
  logic [W-1:0] wr_data, int_vector;
  logic [1:0]   sp_op;
  logic [7:0]   sp_step;
  logic         int_ack, halted, in_int;
  logic [W-1:0] rd_data, wr_reg, pc, sr, sp;

  asrm_regbank #(
    .WORDSIZE(W), .PC_RESET(16'h0100), .SP_RESET(16'h0002),
    .SR_RESET(16'h0055), .GP_RESET(16'hA5A5), .INT_LATENCY(2)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .wr_valid(wr_valid), .wr_idx(wr_idx),
    .wr_data(wr_data), .sp_op(sp_op), .sp_step(sp_step), .halt_req(halt_req),
    .reti(reti), .int_req(int_req), .int_vector(int_vector), .int_ack(int_ack),
    .rd_idx(rd_idx), .rd_data(rd_data), .wr_reg(wr_reg), .pc(pc), .sr(sr), .sp(sp),
    .halted(halted), .in_int(in_int)
  );

  always #5 clk = ~clk;

  typedef enum int {S_PC, S_SP, S_SR, S_WR, S_RD, S_INT, S_HALT, S_ACK} sel_t;
  typedef struct {string tag; sel_t sel; logic [W-1:0] val;} exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic expect_v(input string tag, input sel_t sel, input logic [W-1:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = v;
    q.push_back(e);
  endtask

  task automatic expect_core(input string tag, input logic [W-1:0] p,
                             input logic ii, input logic hh, input logic aa);
    expect_v({tag, ".pc"}, S_PC, p);
    expect_v({tag, ".in_int"}, S_INT, W'(ii));
    expect_v({tag, ".halted"}, S_HALT, W'(hh));
    expect_v({tag, ".int_ack"}, S_ACK, W'(aa));
  endtask

  function automatic logic [W-1:0] observe(input sel_t sel);
    case (sel)
      S_PC:    return pc;
      S_SP:    return sp;
      S_SR:    return sr;
      S_WR:    return wr_reg;
      S_RD:    return rd_data;
      S_INT:   return W'(in_int);
      S_HALT:  return W'(halted);
      default: return W'(int_ack);
    endcase
  endfunction

  task automatic tick();
    exp_t         e;
    logic [W-1:0] o;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = observe(e.sel);
      n_cmp++;
      assert (o === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic idle();
    stall = 0; wr_valid = 0; wr_idx = 0; wr_data = 0; sp_op = 0; sp_step = 0;
    halt_req = 0; reti = 0; int_req = 0;
  endtask

  initial begin
    idle();
    reset = 0; rd_idx = 4'd7; int_vector = 16'h0200;
    tick();
    expect_core("reset", 16'h0100, 0, 0, 0);
    expect_v("reset.sp", S_SP, 16'h0002);
    expect_v("reset.sr", S_SR, 16'h0055);
    expect_v("reset.wr", S_WR, 16'hA5A5);
    expect_v("reset.r7", S_RD, 16'hA5A5);
    tick();

    reset = 1;
    tick(); tick();
    expect_core("run3", 16'h0103, 0, 0, 0);
    expect_v("run3.sp", S_SP, 16'h0002);
    expect_v("run3.sr", S_SR, 16'h0055);
    expect_v("run3.wr", S_WR, 16'hA5A5);
    tick();

    sp_op = 2'b10; sp_step = 8'd4;
    expect_v("sp_sub_wrap", S_SP, 16'hFFFE);
    expect_v("sp_sub_wrap.pc", S_PC, 16'h0104);
    tick();

    wr_valid = 1; wr_idx = 4'd3; wr_data = 16'h1234;
    expect_v("sp_wr_prio", S_SP, 16'h1234);
    expect_v("sp_wr_prio.pc", S_PC, 16'h0105);
    tick();

    wr_valid = 0; sp_op = 2'b01; sp_step = 8'hFF;
    expect_v("sp_add", S_SP, 16'h1333);
    tick();

    sp_op = 2'b11; sp_step = 8'h10;
    expect_v("sp_reserved", S_SP, 16'h1333);
    expect_v("sp_reserved.pc", S_PC, 16'h0107);
    tick();

    sp_op = 0; wr_valid = 1; wr_idx = 4'd9; wr_data = 16'hBEEF; rd_idx = 4'd9;
    expect_v("gp_write", S_RD, 16'hBEEF);
    expect_v("gp_write.pc", S_PC, 16'h0108);
    tick();

    wr_idx = 4'd1; wr_data = 16'h0010;
    expect_v("pc_write", S_PC, 16'h0010);
    tick();

    // Interrupt accept: the concurrent write and SP op must be dropped.
    int_req = 1; wr_idx = 4'd9; wr_data = 16'h0000; sp_op = 2'b01; sp_step = 8'd1;
    expect_core("int_accept", 16'h0010, 1, 0, 1);
    expect_v("int_accept.r9", S_RD, 16'hBEEF);
    expect_v("int_accept.sp", S_SP, 16'h1333);
    tick();

    idle();
    expect_core("enter1", 16'h0010, 1, 0, 0);
    tick();
    expect_core("enter_done", 16'h0200, 1, 0, 0);
    tick();

    int_req = 1;
    expect_core("nest_ignored", 16'h0201, 1, 0, 0);
    tick();

    stall = 1; wr_valid = 1; wr_idx = 4'd4; wr_data = 16'h1111; rd_idx = 4'd4; sp_op = 2'b01;
    for (int i = 0; i < 5; i++) begin
      expect_core("stall", 16'h0201, 1, 0, 0);
      expect_v("stall.r4", S_RD, 16'hA5A5);
      expect_v("stall.sp", S_SP, 16'h1333);
      tick();
    end

    idle();
    reti = 1; wr_valid = 1; wr_idx = 4'd2; wr_data = 16'h00FF;
    expect_core("reti", 16'h0010, 0, 0, 0);
    expect_v("reti.sr", S_SR, 16'h00FF);
    tick();

    wr_valid = 0;
    expect_core("reti_noint", 16'h0011, 0, 0, 0);
    tick();

    reti = 0; wr_valid = 1; wr_idx = 4'd1; wr_data = 16'h0040;
    expect_v("pc_write40", S_PC, 16'h0040);
    tick();
    wr_valid = 0;
    expect_v("pc_inc41", S_PC, 16'h0041);
    tick();

    int_req = 1;
    expect_core("int_accept2", 16'h0041, 1, 0, 1);
    tick();

    // Reset in the middle of ENTER, with stall held high.
    int_req = 0; reset = 0; stall = 1;
    expect_core("reset_mid_enter", 16'h0100, 0, 0, 0);
    expect_v("reset_mid_enter.sr", S_SR, 16'h0055);
    expect_v("reset_mid_enter.sp", S_SP, 16'h0002);
    tick();

    reset = 1; stall = 0;
    expect_core("post_reset_run", 16'h0101, 0, 0, 0);
    tick();

    halt_req = 1; int_req = 1; wr_valid = 1; wr_idx = 4'd5; wr_data = 16'h7777; rd_idx = 4'd5;
    expect_core("halt", 16'h0101, 0, 1, 0);
    expect_v("halt.r5", S_RD, 16'hA5A5);
    tick();

    halt_req = 0; reti = 1;
    for (int i = 0; i < 2; i++) begin
      expect_core("halt_hold", 16'h0101, 0, 1, 0);
      expect_v("halt_hold.r5", S_RD, 16'hA5A5);
      tick();
    end

    idle();
    reset = 0;
    expect_core("halt_reset", 16'h0100, 0, 0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
